// File: rtl/clk_mon_pkg.sv
// Shared types and default parameters for the divided-clock monitor.
package clk_mon_pkg;

    localparam int CNT_W_DEF       = 16;
    localparam int LOCK_CNT_DEF    = 4;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        SEEK   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_e;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous level, followed by single-cycle
// rise/fall pulse generation in the destination clock domain.
module sync_edge_det #(
    parameter int STAGES = 2
)(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], async_i};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign rise_o = r_sync[STAGES-1] & ~r_prev;
    assign fall_o = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/clk_div_monitor.sv
// Divided-clock monitor: measures period and high time of div_clk_i in clk_i
// cycles, declares lock after a run of in-tolerance periods, flags deviations.
module clk_div_monitor
    import clk_mon_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int LOCK_CNT    = LOCK_CNT_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
)(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             div_clk_i,
    input  logic             clear_i,
    input  logic [CNT_W-1:0] exp_period_i,
    input  logic [3:0]       tol_i,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             meas_valid_o,
    output logic             locked_o,
    output logic             err_o,
    output state_e           dbg_state_o
);

    localparam int              MC_W     = $clog2(LOCK_CNT + 1);
    localparam logic [MC_W-1:0] LOCK_TGT = MC_W'(LOCK_CNT);

    logic w_rise;
    logic w_fall;

    sync_edge_det #(
        .STAGES (SYNC_STAGES)
    ) u_sync_edge_det (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .async_i (div_clk_i),
        .rise_o  (w_rise),
        .fall_o  (w_fall)
    );

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_shadow;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high;
    logic             r_meas_valid;
    logic             r_locked;
    logic             r_err;
    logic [MC_W-1:0]  r_match_cnt;
    state_e           r_state;

    // Counter restarts at 1 so the value seen on the next rise is the period.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (w_rise) begin
            r_cnt <= CNT_W'(1);
        end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // One extra bit keeps |cnt - exp| and exp + tol free of overflow.
    logic [CNT_W:0] w_cnt_x;
    logic [CNT_W:0] w_exp_x;
    logic [CNT_W:0] w_tol_x;
    logic [CNT_W:0] w_diff;
    logic [CNT_W:0] w_limit;
    logic           w_match;
    logic           w_timeout;

    assign w_cnt_x   = {1'b0, r_cnt};
    assign w_exp_x   = {1'b0, exp_period_i};
    assign w_tol_x   = {{(CNT_W-3){1'b0}}, tol_i};
    assign w_diff    = (w_cnt_x >= w_exp_x) ? (w_cnt_x - w_exp_x) : (w_exp_x - w_cnt_x);
    assign w_limit   = w_exp_x + w_tol_x;
    assign w_match   = (w_diff <= w_tol_x);
    assign w_timeout = (w_cnt_x > w_limit);

    state_e          w_state_nx;
    logic [MC_W-1:0] w_mc_nx;
    logic [MC_W-1:0] w_mc_inc;
    logic            w_err_nx;
    logic            w_meas;

    assign w_mc_inc = r_match_cnt + MC_W'(1);

    always_comb begin
        w_state_nx = r_state;
        w_mc_nx    = r_match_cnt;
        w_err_nx   = r_err;
        w_meas     = 1'b0;
        if (clear_i) begin
            w_state_nx = SEEK;
            w_mc_nx    = '0;
            w_err_nx   = 1'b0;
        end else begin
            case (r_state)
                SEEK: begin
                    if (w_rise) begin
                        w_state_nx = TRACK;
                        w_mc_nx    = '0;
                    end
                end
                TRACK: begin
                    if (w_rise) begin
                        w_meas = 1'b1;
                        if (w_match) begin
                            w_mc_nx = w_mc_inc;
                            if (w_mc_inc >= LOCK_TGT) begin
                                w_state_nx = LOCKED;
                            end
                        end else begin
                            w_mc_nx = '0;
                        end
                    end else if (w_timeout) begin
                        w_state_nx = SEEK;
                    end
                end
                LOCKED: begin
                    if (w_rise) begin
                        w_meas = 1'b1;
                        if (!w_match) begin
                            w_err_nx   = 1'b1;
                            w_state_nx = TRACK;
                            w_mc_nx    = '0;
                        end
                    end else if (w_timeout) begin
                        w_err_nx   = 1'b1;
                        w_state_nx = SEEK;
                    end
                end
                default: begin
                    w_state_nx = SEEK;
                    w_mc_nx    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= SEEK;
            r_match_cnt  <= '0;
            r_err        <= 1'b0;
            r_locked     <= 1'b0;
            r_meas_valid <= 1'b0;
            r_period     <= '0;
            r_high       <= '0;
            r_shadow     <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_match_cnt  <= w_mc_nx;
            r_err        <= w_err_nx;
            r_locked     <= (w_state_nx == LOCKED);
            r_meas_valid <= w_meas;
            if (w_meas) begin
                r_period <= r_cnt;
                r_high   <= r_shadow;
            end
            if (w_fall && !clear_i) begin
                r_shadow <= r_cnt;
            end
        end
    end

    assign period_o     = r_period;
    assign high_o       = r_high;
    assign meas_valid_o = r_meas_valid;
    assign locked_o     = r_locked;
    assign err_o        = r_err;
    assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: table of divided-clock periods with expected
// measurements queued per period, plus hand-written timeout/clear/reset cases.
module tb_clk_div_monitor;
    import clk_mon_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        div_clk = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] exp_period = 16'd4;
    logic [3:0]  tol = 4'd0;
    logic [15:0] period_o;
    logic [15:0] high_o;
    logic        meas_valid_o;
    logic        locked_o;
    logic        err_o;
    state_e      dbg_state;

    int          n_checks = 0;
    int          n_errors = 0;
    bit          sb_async = 1'b0;
    int          async_meas = 0;
    logic [33:0] exp_q[$];

    clk_div_monitor dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .div_clk_i    (div_clk),
        .clear_i      (clear),
        .exp_period_i (exp_period),
        .tol_i        (tol),
        .period_o     (period_o),
        .high_o       (high_o),
        .meas_valid_o (meas_valid_o),
        .locked_o     (locked_o),
        .err_o        (err_o),
        .dbg_state_o  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input bit ok, input string detail);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    // Scoreboard: every meas_valid_o pulse consumes one queued expectation.
    always @(negedge clk) begin
        logic [33:0] e;
        if (rst_n && meas_valid_o) begin
            if (sb_async) begin
                async_meas++;
                check("async_meas",
                      (int'(period_o) >= int'(exp_period) - int'(tol)) &&
                      (int'(period_o) <= int'(exp_period) + int'(tol)) && !err_o,
                      $sformatf("got period=%0d err=%0d, required %0d+-%0d err=0",
                                period_o, err_o, exp_period, tol));
            end else if (exp_q.size() == 0) begin
                check("unexpected_meas", 1'b0,
                      $sformatf("got period=%0d high=%0d, required no measurement",
                                period_o, high_o));
            end else begin
                e = exp_q.pop_front();
                check("meas", {period_o, high_o, locked_o, err_o} == e,
                      $sformatf("got per=%0d high=%0d lock=%0d err=%0d, required per=%0d high=%0d lock=%0d err=%0d",
                                period_o, high_o, locked_o, err_o,
                                e[33:18], e[17:2], e[1], e[0]));
            end
        end
    end

    typedef struct {
        int          h;
        int          l;
        logic [15:0] ep;
        logic [3:0]  tl;
        bit          m;
        logic [15:0] per;
        logic [15:0] hi;
        logic        lk;
        logic        er;
    } vec_t;

    function automatic vec_t mk(input int h, input int l, input int ep, input int tl,
                                input bit m, input int per, input int hi,
                                input bit lk, input bit er);
        vec_t v;
        v.h = h; v.l = l; v.ep = 16'(ep); v.tl = 4'(tl); v.m = m;
        v.per = 16'(per); v.hi = 16'(hi); v.lk = lk; v.er = er;
        return v;
    endfunction

    // One divided-clock period starting with a rising edge. The expected
    // measurement of this period is reported at the next period's rise.
    // exp/tol change at cycle 3, after the previous rise has been evaluated.
    task automatic run_row(input vec_t v, input int clr_c);
        if (v.m) exp_q.push_back({v.per, v.hi, v.lk, v.er});
        for (int c = 0; c < v.h + v.l; c++) begin
            @(posedge clk); #1;
            div_clk = (c < v.h);
            if (c == 3) begin
                exp_period = v.ep;
                tol        = v.tl;
            end
            clear = (c == clr_c);
        end
    endtask

    task automatic close_out();
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            div_clk = (c < 2);
        end
        check("queue_drained", exp_q.size() == 0,
              $sformatf("got %0d pending, required 0", exp_q.size()));
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
    endtask

    task automatic run_div4(input int n, input bit er, input int lock_at);
        for (int i = 1; i <= n; i++) begin
            run_row(mk(2, 2, 4, 0, 1, 4, 2, (i >= lock_at), er), -1);
        end
    endtask

    vec_t tbl[16];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mk(2, 2, 4, 0, 1, 4, 2, 0, 0);
        tbl[1]  = mk(2, 2, 4, 0, 1, 4, 2, 0, 0);
        tbl[2]  = mk(2, 2, 4, 0, 1, 4, 2, 0, 0);
        tbl[3]  = mk(2, 2, 4, 0, 1, 4, 2, 1, 0);
        tbl[4]  = mk(2, 2, 4, 0, 1, 4, 2, 1, 0);
        tbl[5]  = mk(4, 4, 4, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk(4, 4, 8, 0, 1, 8, 4, 0, 1);
        tbl[7]  = mk(4, 4, 8, 0, 1, 8, 4, 0, 1);
        tbl[8]  = mk(4, 4, 8, 0, 1, 8, 4, 0, 1);
        tbl[9]  = mk(4, 4, 8, 0, 1, 8, 4, 1, 1);
        tbl[10] = mk(3, 5, 8, 1, 1, 8, 3, 1, 1);
        tbl[11] = mk(4, 5, 8, 1, 1, 9, 4, 1, 1);
        tbl[12] = mk(3, 4, 8, 1, 1, 7, 3, 1, 1);
        tbl[13] = mk(3, 3, 8, 1, 1, 6, 3, 0, 1);
        tbl[14] = mk(3, 3, 6, 0, 1, 6, 3, 0, 1);
        tbl[15] = mk(2, 2, 6, 0, 1, 4, 2, 0, 1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              period_o == 0 && high_o == 0 && !meas_valid_o && !locked_o && !err_o,
              $sformatf("got per=%0d high=%0d mv=%0d lock=%0d err=%0d, required all 0",
                        period_o, high_o, meas_valid_o, locked_o, err_o));
        check("reset_state", dbg_state == SEEK,
              $sformatf("got %0d, required SEEK", dbg_state));
        @(posedge clk); #1 rst_n = 1'b1;

        // Lock at /4, lose lock to a /8 stream via timeout, relock, tolerance edges.
        foreach (tbl[i]) run_row(tbl[i], -1);
        close_out();

        // Asynchronous /4 source with drifting phase, tolerance 1.
        exp_period = 16'd4;
        tol        = 4'd1;
        pulse_clear();
        sb_async = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            int j;
            j = $urandom_range(0, 1);
            div_clk = 1'b1;
            #20;
            div_clk = 1'b0;
            #(21 + j);
        end
        check("async_locked", locked_o == 1'b1,
              $sformatf("got %0d, required 1", locked_o));
        check("async_no_err", err_o == 1'b0,
              $sformatf("got %0d, required 0", err_o));
        check("async_meas_count", async_meas >= 990,
              $sformatf("got %0d, required >= 990", async_meas));
        sb_async = 1'b0;

        // Lock again synchronously, then hold div_clk low.
        @(posedge clk); #1;
        tol = 4'd0;
        pulse_clear();
        run_div4(5, 1'b0, 4);
        @(posedge clk); #1 div_clk = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            @(posedge clk); #1;
            if (c == 2) div_clk = 1'b0;
            if (c == 7) check("hold_low_pre", dbg_state == LOCKED && !err_o,
                              $sformatf("got state=%0d err=%0d, required LOCKED err=0",
                                        dbg_state, err_o));
            if (c == 8) check("hold_low_timeout",
                              dbg_state == SEEK && err_o && !locked_o,
                              $sformatf("got state=%0d err=%0d lock=%0d, required SEEK err=1 lock=0",
                                        dbg_state, err_o, locked_o));
        end

        // Edges resume; then a clear lands on the same cycle as a rise.
        run_row(mk(2, 2, 4, 0, 1, 4, 2, 0, 1), -1);
        run_row(mk(2, 2, 4, 0, 0, 0, 0, 0, 0), -1);
        run_row(mk(2, 2, 4, 0, 0, 0, 0, 0, 0), 2);
        check("clear_on_rise",
              dbg_state == SEEK && !err_o && !locked_o && !meas_valid_o,
              $sformatf("got state=%0d err=%0d lock=%0d mv=%0d, required SEEK 0 0 0",
                        dbg_state, err_o, locked_o, meas_valid_o));
        run_div4(4, 1'b0, 4);

        // Asynchronous reset in the middle of a locked period.
        @(posedge clk); #1 div_clk = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            if (c == 2) div_clk = 1'b0;
        end
        check("locked_before_reset", locked_o == 1'b1,
              $sformatf("got %0d, required 1", locked_o));
        #3 rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              period_o == 0 && high_o == 0 && !meas_valid_o && !locked_o && !err_o &&
              dbg_state == SEEK,
              $sformatf("got per=%0d high=%0d mv=%0d lock=%0d err=%0d state=%0d, required zeros/SEEK",
                        period_o, high_o, meas_valid_o, locked_o, err_o, dbg_state));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run_div4(4, 1'b0, 4);
        close_out();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clk_div_monitor.md
# clk_div_monitor

Measures a divided clock (e.g. the divide-by-4 output) against the system clock and reports its period and high time in `clk_i` cycles. It declares lock after a run of in-tolerance periods and raises a sticky error on any later deviation or loss of edges. It sits next to the clock dividers as their checking/receiving end, for built-in self-check and for the verification benches.

## Interface
- `CNT_W`, 16: width of the cycle counters and measurement outputs.
- `LOCK_CNT`, 4: consecutive in-tolerance periods required to assert lock (≥1).
- `SYNC_STAGES`, 2: synchronizer depth for `div_clk_i` (≥2).
- `clk_i`  in  1  system clock, sole clock of the block.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `div_clk_i`  in  1  monitored clock, asynchronous to `clk_i`, treated as data.
- `clear_i`  in  1  synchronous clear of error/lock state, single-cycle pulse.
- `exp_period_i`  in  CNT_W  expected period in `clk_i` cycles; static while locked.
- `tol_i`  in  4  allowed ±deviation in cycles.
- `period_o`  out  CNT_W  last measured period.
- `high_o`  out  CNT_W  last measured high time.
- `meas_valid_o`  out  1  one-cycle pulse when `period_o`/`high_o` update.
- `locked_o`  out  1  lock indicator.
- `err_o`  out  1  sticky error.

## Operation
- `div_clk_i` passes through a `SYNC_STAGES` flop chain, then a one-flop edge detector producing `rise`/`fall` pulses. The chain resets to 0, so a high input at reset release yields one spurious rise, which SEEK absorbs.
- Cycle counter `cnt`:
  - loads 1 in the cycle after `rise`, otherwise increments;
  - saturates at all-ones, never wraps.
- On `fall`, `cnt` is latched into a high-time shadow register.
- On `rise` outside SEEK:
  - `period_o` ← `cnt`, `high_o` ← shadow;
  - `meas_valid_o` pulses in the next cycle.
- Match test: |`cnt` − `exp_period_i`| ≤ `tol_i`, computed at CNT_W+1 bits, unsigned, no overflow.
- FSM states SEEK, TRACK, LOCKED, with an internal `match_cnt` of width $clog2(LOCK_CNT+1):
  - SEEK: wait for `rise`, then go to TRACK with `match_cnt`=0; no measurement is reported.
  - TRACK, `rise` with match: `match_cnt`+1; on reaching LOCK_CNT, go to LOCKED and set `locked_o`=1.
  - TRACK, `rise` with mismatch: `match_cnt`=0, stay in TRACK; `err_o` unaffected.
  - LOCKED, `rise` with mismatch: `err_o`=1, `locked_o`=0, go to TRACK with `match_cnt`=0.
- Timeout, when `cnt` > `exp_period_i` + `tol_i` with no `rise` yet:
  - from TRACK: go to SEEK;
  - from LOCKED: go to SEEK, set `err_o`=1, clear `locked_o`.
- `clear_i`:
  - clears `err_o`, `locked_o` and `match_cnt`, and forces SEEK;
  - takes priority over a simultaneous `rise`, `fall` or timeout in the same cycle; that edge's measurement is discarded.
- `err_o` clears only via `clear_i` or reset.

## Timing
- Reset values: `period_o`=0, `high_o`=0, `meas_valid_o`=0, `locked_o`=0, `err_o`=0; FSM in SEEK; synchronizer and counter at 0.
- Input edge to `rise`/`fall` pulse: SYNC_STAGES+1 `clk_i` cycles. Each measurement carries ±1 cycle of synchronizer uncertainty; set `tol_i` ≥1 for truly asynchronous sources.
- `rise` to `meas_valid_o`: 1 cycle. `locked_o` and `err_o` update in the same cycle as `meas_valid_o`.
- Timeout flags take effect 1 cycle after the threshold is crossed.
- Valid input range: high and low phases each ≥2 `clk_i` cycles. Below that, results are undefined but the FSM must stay in a legal state.
- Reset asserted mid-measurement returns all state to reset values immediately (asynchronously); release is synchronous to `clk_i`.

## Structure
- `clk_mon_pkg`: `state_e` enum {SEEK, TRACK, LOCKED} and the default constants for `CNT_W`, `LOCK_CNT` and `SYNC_STAGES`.
- Sub-module `sync_edge_det`: parameterised synchronizer plus rise/fall pulse generation, reusable by other blocks.
- Counter, match comparator and FSM live in the top module.

## Test plan
- Synchronous ÷4 input (2 high/2 low), `exp_period_i`=4, `tol_i`=0 → `period_o`=4, `high_o`=2 on every `meas_valid_o`; `locked_o`=1 after the 4th valid measurement; `err_o` stays 0.
- Locked at ÷4, then switch to ÷8 → next measurement reports period 8, `err_o`=1, `locked_o`=0; relocks after 4 periods with `exp_period_i`=8; `err_o` remains 1 until `clear_i`.
- Locked, then hold `div_clk_i` low → `err_o`=1 and SEEK entered 1 cycle after `cnt` reaches 5; no `meas_valid_o` until the edges resume and a full period completes.
- Asynchronous ÷4 source with phase jitter, `tol_i`=1 → lock achieved, no error over 1000 periods.
- `clear_i` coincident with `rise` → no `meas_valid_o` for that edge; FSM in SEEK, `err_o`=0.
- `rst_ni` pulsed low mid-period while locked → all outputs return to 0 asynchronously; lock is re-established after LOCK_CNT+1 rises.
